// File: rtl/mult_pkg.sv
// Shared types for the radix-2 Booth multiplier control path.
package mult_pkg;

    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic shift_HQ_LQ_Q_1;
        logic add_sub;
    } mult_control_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        EVAL,
        SHIFT,
        CAPT,
        HOLD
    } booth_state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step_counter.sv
// Iteration counter for the Booth sequencer; flags the last evaluate/shift step.
module booth_step_counter #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    // One extra value of headroom so the final increment never wraps.
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign last = (count == CW'(N - 1));

endmodule

// File: rtl/booth_mult_ctrl.sv
// Booth multiplier sequencer: clear, load, N eval/shift steps, capture, valid/ready hold.
module booth_mult_ctrl
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            start_ready,
    input  logic [2:0]      Q_LSB,
    input  logic [2*N-1:0]  bin_d_in,
    output mult_control_t   mult_control,
    output logic            dp_clr,
    output logic            busy,
    output logic [2*N-1:0]  product,
    output logic            product_valid,
    input  logic            product_ready
);

    booth_state_t state, state_nxt;
    logic         cnt_clear, cnt_inc, cnt_last;
    logic         unused_q_msb;

    assign unused_q_msb = Q_LSB[2];
    assign cnt_clear    = (state == CLEAR);
    assign cnt_inc      = (state == SHIFT);

    booth_step_counter #(.N(N)) u_step_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD;
            LOAD:    state_nxt = EVAL;
            EVAL:    state_nxt = SHIFT;
            SHIFT:   state_nxt = cnt_last ? CAPT : EVAL;
            CAPT:    state_nxt = HOLD;
            HOLD:    if (product_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mult_control  = '0;
        dp_clr        = 1'b0;
        start_ready   = 1'b0;
        product_valid = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE:  start_ready = 1'b1;
            CLEAR: dp_clr = 1'b1;
            LOAD: begin
                mult_control.load_A = 1'b1;
                mult_control.load_B = 1'b1;
            end
            // Mealy decode of the datapath's registered {LQ[0], Q_1}.
            EVAL: begin
                case (Q_LSB[1:0])
                    BOOTH_ADD: begin
                        mult_control.load_add = 1'b1;
                        mult_control.add_sub  = 1'b1;
                    end
                    BOOTH_SUB: mult_control.load_add = 1'b1;
                    default: ;
                endcase
            end
            SHIFT: mult_control.shift_HQ_LQ_Q_1 = 1'b1;
            HOLD:  product_valid = 1'b1;
            default: ;
        endcase
    end

    // Product survives the handshake; only the next CAPT overwrites it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            product <= '0;
        else if (state == CAPT)
            product <= bin_d_in;
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Bench for booth_mult_ctrl: golden Booth datapath model, vector table, scoreboard queue.
module tb_booth_mult_ctrl;
    import mult_pkg::*;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            rst, start, product_ready;
    logic            start_ready, dp_clr, busy, product_valid;
    logic [2:0]      Q_LSB;
    logic [2*N-1:0]  bin_d_in, product;
    mult_control_t   mult_control;

    always #5 clk = ~clk;

    booth_mult_ctrl #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_ready   (start_ready),
        .Q_LSB         (Q_LSB),
        .bin_d_in      (bin_d_in),
        .mult_control  (mult_control),
        .dp_clr        (dp_clr),
        .busy          (busy),
        .product       (product),
        .product_valid (product_valid),
        .product_ready (product_ready)
    );

    // Golden datapath; HQ carries a guard bit so -(-2^(N-1)) does not overflow.
    logic [N-1:0] a_in, b_in, a_reg;
    logic [N:0]   hq;
    logic [N-1:0] lq;
    logic         q1;

    always @(posedge clk) begin
        if (mult_control.load_A) a_reg <= a_in;
        if (dp_clr) begin
            hq <= '0; lq <= '0; q1 <= 1'b0;
        end else if (mult_control.load_B) begin
            lq <= b_in;
        end else if (mult_control.load_add) begin
            hq <= mult_control.add_sub ? hq + {a_reg[N-1], a_reg} : hq - {a_reg[N-1], a_reg};
        end else if (mult_control.shift_HQ_LQ_Q_1) begin
            hq <= {hq[N], hq[N:1]};
            lq <= {hq[0], lq[N-1:1]};
            q1 <= lq[0];
        end
    end

    assign Q_LSB    = {1'b0, lq[0], q1};
    assign bin_d_in = {hq[N-1:0], lq};

    // Protocol monitor: shifts, add/sub decisions taken in the EVAL before each shift.
    int       n_shift = 0, n_add = 0, n_sub = 0, viol = 0;
    logic     p_ld_add = 1'b0, p_add_sub = 1'b0, p_clr = 1'b0;
    logic [1:0] p_q = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            if (mult_control.load_add && mult_control.shift_HQ_LQ_Q_1) viol <= viol + 1;
            if (mult_control.load_A != mult_control.load_B) viol <= viol + 1;
            if (mult_control.load_A && !p_clr) viol <= viol + 1;
            if (mult_control.shift_HQ_LQ_Q_1) begin
                n_shift <= n_shift + 1;
                if (p_ld_add != (p_q == 2'b01 || p_q == 2'b10)) viol <= viol + 1;
                if (p_ld_add && (p_add_sub != (p_q == 2'b01))) viol <= viol + 1;
                if (p_ld_add && p_add_sub)  n_add <= n_add + 1;
                if (p_ld_add && !p_add_sub) n_sub <= n_sub + 1;
            end
        end
        p_ld_add  <= mult_control.load_add;
        p_add_sub <= mult_control.add_sub;
        p_clr     <= dp_clr;
        p_q       <= Q_LSB[1:0];
    end

    int tests = 0, fails = 0;
    logic [2*N-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one multiply; returns cycles from start sample to product_valid (0 on timeout).
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input int pulse_at, output int lat);
        int sh0;
        sh0 = n_shift;
        @(negedge clk);
        a_in = a; b_in = b; product_ready = 1'b0;
        chk("start_ready_idle", {31'd0, start_ready}, 32'd1);
        start = 1'b1;
        sb.push_back(exp);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = (k == pulse_at);
            if (k == pulse_at) chk("start_ready_busy", {31'd0, start_ready}, 32'd0);
            if (product_valid) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        chk("latency", lat, 32'd20);
        chk("shift_count", n_shift - sh0, 32'd8);
    endtask

    // Complete the handshake at the current negedge; optional simultaneous start.
    task automatic handshake(input logic with_start);
        logic [2*N-1:0] exp;
        product_ready = 1'b1;
        start = with_start;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            chk("product", {16'd0, product}, {16'd0, exp});
        end
        @(negedge clk);
        product_ready = 1'b0;
        start = 1'b0;
        chk("idle_after_hs", {30'd0, start_ready, product_valid}, 32'b10);
    endtask

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
        int             adds;
        int             subs;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, a0, s0, shifts_seen;
        logic [2*N-1:0] held;

        vecs[0] = '{8'h03, 8'h05, 16'h000F, 2, 2};
        vecs[1] = '{8'hFD, 8'h05, 16'hFFF1, 2, 2};
        vecs[2] = '{8'h80, 8'h80, 16'h4000, 0, 1};
        vecs[3] = '{8'h00, 8'h7F, 16'h0000, 1, 1};
        vecs[4] = '{8'h7F, 8'h7F, 16'h3F01, 1, 1};
        vecs[5] = '{8'hFF, 8'hFF, 16'h0001, 0, 1};
        vecs[6] = '{8'h80, 8'h7F, 16'hC080, 1, 1};
        vecs[7] = '{8'h7F, 8'h80, 16'hC080, 0, 1};
        vecs[8] = '{8'h55, 8'hAA, 16'hE372, 3, 4};

        rst = 1'b0; start = 1'b0; product_ready = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {mult_control, dp_clr, busy, product_valid, start_ready},
            {5'b0, 4'b0001});
        chk("reset_product", {16'd0, product}, 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            a0 = n_add; s0 = n_sub;
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, lat);
            chk("add_count", n_add - a0, vecs[i].adds);
            chk("sub_count", n_sub - s0, vecs[i].subs);
            handshake(1'b0);
        end

        // Back-pressure: result must hold while the consumer stalls.
        run_op(8'h09, 8'hF9, 16'hFFC1, 0, lat);
        held = sb[0];
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_stable", {14'd0, product_valid, start_ready, product}, {14'd0, 2'b10, held});
        end
        handshake(1'b0);

        // Start during a run is dropped; start alongside ready in HOLD does not launch a run.
        run_op(8'h0C, 8'h0D, 16'h009C, 5, lat);
        handshake(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_new_run", {31'd0, busy}, 32'd0);
        end
        chk("single_result", sb.size(), 32'd0);

        // Asynchronous reset in the 4th SHIFT kills the run without a result.
        @(negedge clk);
        a_in = 8'h21; b_in = 8'h03; start = 1'b1;
        shifts_seen = 0;
        for (int k = 0; k < 40 && shifts_seen < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mult_control.shift_HQ_LQ_Q_1) shifts_seen++;
        end
        chk("fourth_shift_reached", shifts_seen, 32'd4);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {mult_control, dp_clr, busy, product_valid, start_ready},
            {5'b0, 4'b0001});
        chk("async_reset_product", {16'd0, product}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(8'hF0, 8'h10, 16'hFF00, 0, lat);
        handshake(1'b0);

        repeat (3) @(negedge clk);
        chk("protocol_violations", viol, 32'd0);
        chk("queue_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
